// File: rtl/port_frame_buf_pkg.sv
// Shared definitions for the port frame buffer.
//   state_t    : frame FSM encoding (IDLE=0, FILL=1, DROP=2, DRAIN=3)
//   ADDR_W_DEF : default log2 of the frame buffer depth in bytes
package port_frame_buf_pkg;

  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DROP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/port_frame_buf_ram.sv
// frame_buf_ram: DEPTH x 8 distributed RAM holding one frame.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write byte
//   i_raddr : read address
//   o_rdata : read byte (asynchronous, combinational from i_raddr)
module frame_buf_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/port_frame_buf.sv
// port_frame_buf: store-and-forward buffer for a single byte-wide frame.
// A whole frame is written into frame_buf_ram, then replayed downstream.
// Frames longer than the buffer are truncated to DEPTH bytes and the sticky
// overflow flag is raised.
//   clk, rst                               : clock, synchronous active-high reset
//   en_wr, en_rd                           : channel enables from the router
//   in_data/in_sof/in_eof/in_src_rdy       : input beat
//   in_dst_rdy                             : input beat accepted
//   out_data/out_sof/out_eof/out_src_rdy   : output beat
//   out_dst_rdy                            : downstream accepts output beat
//   overflow                               : sticky, a frame was truncated
module port_frame_buf
  import port_frame_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_wr,
  input  logic       en_rd,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       in_src_rdy,
  output logic       in_dst_rdy,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_src_rdy,
  input  logic       out_dst_rdy,
  output logic       overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_len;
  logic              r_overflow;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_rdata;
  logic              w_full;
  logic              w_last;

  assign w_in_xfer  = in_src_rdy & in_dst_rdy;
  assign w_out_xfer = out_src_rdy & out_dst_rdy;
  assign w_full     = (r_wr_ptr == '1);
  assign w_last     = ({1'b0, r_rd_ptr} == (r_len - (ADDR_W+1)'(1)));

  // Any sof beat (re)starts the frame at address 0; only FILL stores
  // continuation beats, so IDLE strays and DROP tails never touch the RAM.
  assign w_we    = w_in_xfer & (in_sof | (r_state == ST_FILL));
  assign w_waddr = in_sof ? '0 : r_wr_ptr;

  frame_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer && in_sof) w_next = in_eof ? ST_DRAIN : ST_FILL;
      end
      ST_FILL: begin
        if (w_in_xfer) begin
          if (in_sof)      w_next = in_eof ? ST_DRAIN : ST_FILL;
          else if (in_eof) w_next = ST_DRAIN;
          else if (w_full) w_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (w_in_xfer) begin
          if (in_sof)      w_next = in_eof ? ST_DRAIN : ST_FILL;
          else if (in_eof) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_out_xfer && w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_dst_rdy  = en_wr;
    out_src_rdy = 1'b0;
    out_sof     = 1'b0;
    out_eof     = 1'b0;
    out_data    = '0;
    if (r_state == ST_DRAIN) begin
      in_dst_rdy  = 1'b0;
      out_src_rdy = en_rd;
      out_sof     = (r_rd_ptr == '0);
      out_eof     = w_last;
      out_data    = w_rdata;
    end
  end

  assign overflow = r_overflow;

  // Pointers, length and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_DRAIN) begin
      if (w_out_xfer) begin
        if (w_last) begin
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
        end else begin
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        end
      end
    end else if (w_in_xfer) begin
      if (in_sof) begin
        r_wr_ptr <= ADDR_W'(1);
        if (in_eof) r_len <= (ADDR_W+1)'(1);
      end else if (r_state == ST_FILL) begin
        if (in_eof) begin
          r_len <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
        end else if (w_full) begin
          // Last slot filled without eof: keep wr_ptr parked so it never wraps.
          r_len      <= (ADDR_W+1)'(DEPTH);
          r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
